// File: rtl/csr_pkg.sv
// Shared encodings for the machine-mode CSR responder: commands, CSR addresses,
// SYSTEM funct12 codes, request bus field offsets and trap causes.
package csr_pkg;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'b000,
        CMD_WRITE  = 3'b001,
        CMD_SET    = 3'b010,
        CMD_CLEAR  = 3'b011,
        CMD_SYSTEM = 3'b100,
        CMD_READ   = 3'b101
    } csr_cmd_e;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_WFI = 1'b1
    } csr_state_e;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MISA     = 12'h301;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    localparam logic [11:0] F12_ECALL  = 12'h000;
    localparam logic [11:0] F12_EBREAK = 12'h001;
    localparam logic [11:0] F12_MRET   = 12'h302;
    localparam logic [11:0] F12_WFI    = 12'h105;

    localparam int REQ_ADDR_LSB   = 197;
    localparam int REQ_CMD_LSB    = 194;
    localparam int REQ_WDATA_LSB  = 130;
    localparam int REQ_XCPT_BIT   = 129;
    localparam int REQ_RETIRE_BIT = 128;
    localparam int REQ_CAUSE_LSB  = 64;
    localparam int REQ_PC_LSB     = 0;

    localparam logic [63:0] CAUSE_BREAKPOINT = 64'd3;
    localparam logic [63:0] CAUSE_ECALL_M    = 64'd11;

    // RV64 with the base integer ISA only
    localparam logic [63:0] MISA_VALUE   = 64'h8000_0000_0000_0100;
    localparam logic [63:0] MIE_WR_MASK  = 64'h0000_0000_0000_0880;
    localparam logic [63:0] ALIGN4_MASK  = 64'hFFFF_FFFF_FFFF_FFFC;

    function automatic logic [63:0] csr_apply(input logic [2:0] cmd,
                                              input logic [63:0] old_val,
                                              input logic [63:0] wdata);
        case (cmd)
            CMD_WRITE: csr_apply = wdata;
            CMD_SET:   csr_apply = old_val | wdata;
            CMD_CLEAR: csr_apply = old_val & ~wdata;
            default:   csr_apply = old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit wrapping counter with a load port; a load beats the increment.
module csr_counter64 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inc,
    input  logic        i_we,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_count
);
    logic [63:0] r_count;

    // counter state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= 64'd0;
        end else if (i_we) begin
            r_count <= i_wdata;
        end else if (i_inc) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: M-mode CSRs, counters, trap entry/MRET and WFI sleep,
// driven by the writeback-stage request bus with fully registered responses.
module csr_file_m
    import csr_pkg::*;
#(
    parameter int          XLEN        = 64,
    parameter logic [63:0] MTVEC_RESET = 64'h0,
    parameter logic [63:0] HART_ID     = 64'h0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [208:0]    req_cpu_csr_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    output logic            csr_trap_o,
    output logic            csr_eret_o,
    output logic [XLEN-1:0] csr_evec_o,
    output logic            csr_stall_o,
    output logic            csr_irq_o
);
    logic [11:0] w_addr;
    logic [2:0]  w_cmd;
    logic [63:0] w_wdata, w_cause, w_pc;
    logic        w_xcpt, w_retire;

    assign w_addr   = req_cpu_csr_i[REQ_ADDR_LSB +: 12];
    assign w_cmd    = req_cpu_csr_i[REQ_CMD_LSB +: 3];
    assign w_wdata  = req_cpu_csr_i[REQ_WDATA_LSB +: 64];
    assign w_xcpt   = req_cpu_csr_i[REQ_XCPT_BIT];
    assign w_retire = req_cpu_csr_i[REQ_RETIRE_BIT];
    assign w_cause  = req_cpu_csr_i[REQ_CAUSE_LSB +: 64];
    assign w_pc     = req_cpu_csr_i[REQ_PC_LSB +: 64];

    logic        r_mie_bit, r_mpie, r_mtip, r_meip;
    logic [63:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [63:0] w_mcycle, w_minstret, w_mstatus, w_mip, w_old, w_new, w_trap_cause;
    logic        w_active, w_cmd_csr, w_cmd_wr, w_mapped, w_csr_illegal, w_csr_do, w_csr_wr;
    logic        w_sys, w_ecall, w_ebreak, w_mret, w_wfi, w_sys_illegal, w_trap;
    csr_state_e  r_state, w_state_next;

    assign w_active  = w_retire & ~w_xcpt;
    assign w_cmd_wr  = (w_cmd == CMD_WRITE) | (w_cmd == CMD_SET) | (w_cmd == CMD_CLEAR);
    assign w_cmd_csr = w_cmd_wr | (w_cmd == CMD_READ);
    assign w_mip     = {52'd0, r_meip, 3'd0, r_mtip, 7'd0};

    // mstatus view: MPP hardwired to machine mode
    always_comb begin
        w_mstatus    = 64'h0000_0000_0000_1800;
        w_mstatus[7] = r_mpie;
        w_mstatus[3] = r_mie_bit;
    end

    // address decode and pre-update read value
    always_comb begin
        w_mapped = 1'b1;
        w_old    = 64'd0;
        case (w_addr)
            ADDR_MSTATUS:                w_old = w_mstatus;
            ADDR_MISA:                   w_old = MISA_VALUE;
            ADDR_MIE:                    w_old = r_mie;
            ADDR_MTVEC:                  w_old = r_mtvec;
            ADDR_MSCRATCH:               w_old = r_mscratch;
            ADDR_MEPC:                   w_old = r_mepc;
            ADDR_MCAUSE:                 w_old = r_mcause;
            ADDR_MTVAL:                  w_old = r_mtval;
            ADDR_MIP:                    w_old = w_mip;
            ADDR_MCYCLE, ADDR_CYCLE:     w_old = w_mcycle;
            ADDR_MINSTRET, ADDR_INSTRET: w_old = w_minstret;
            ADDR_MHARTID:                w_old = HART_ID;
            default:                     w_mapped = 1'b0;
        endcase
    end

    assign w_csr_illegal = w_active & w_cmd_csr &
                           (~w_mapped | (w_cmd_wr & (w_addr[11:10] == 2'b11)));
    assign w_csr_do      = w_active & w_cmd_csr & ~w_csr_illegal;
    assign w_csr_wr      = w_csr_do & w_cmd_wr;
    assign w_new         = csr_apply(w_cmd, w_old, w_wdata);

    assign w_sys         = w_active & (w_cmd == CMD_SYSTEM);
    assign w_ecall       = w_sys & (w_addr == F12_ECALL);
    assign w_ebreak      = w_sys & (w_addr == F12_EBREAK);
    assign w_mret        = w_sys & (w_addr == F12_MRET);
    assign w_wfi         = w_sys & (w_addr == F12_WFI);
    assign w_sys_illegal = w_sys & ~(w_ecall | w_ebreak | w_mret | w_wfi);
    assign w_trap        = w_xcpt | w_ecall | w_ebreak;
    assign w_trap_cause  = w_xcpt ? w_cause : (w_ecall ? CAUSE_ECALL_M : CAUSE_BREAKPOINT);

    // architectural CSR state; a trap always wins over a CSR write
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mie_bit  <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtip     <= 1'b0;
            r_meip     <= 1'b0;
            r_mie      <= 64'd0;
            r_mtvec    <= MTVEC_RESET & ALIGN4_MASK;
            r_mscratch <= 64'd0;
            r_mepc     <= 64'd0;
            r_mcause   <= 64'd0;
            r_mtval    <= 64'd0;
        end else begin
            r_mtip <= irq_timer_i;
            r_meip <= irq_ext_i;
            if (w_trap) begin
                r_mepc    <= w_pc & ALIGN4_MASK;
                r_mcause  <= w_trap_cause;
                r_mpie    <= r_mie_bit;
                r_mie_bit <= 1'b0;
            end else if (w_mret) begin
                r_mie_bit <= r_mpie;
                r_mpie    <= 1'b1;
            end else if (w_csr_wr) begin
                case (w_addr)
                    ADDR_MSTATUS: begin
                        r_mie_bit <= w_new[3];
                        r_mpie    <= w_new[7];
                    end
                    ADDR_MIE:      r_mie      <= w_new & MIE_WR_MASK;
                    ADDR_MTVEC:    r_mtvec    <= w_new & ALIGN4_MASK;
                    ADDR_MSCRATCH: r_mscratch <= w_new;
                    ADDR_MEPC:     r_mepc     <= w_new & ALIGN4_MASK;
                    ADDR_MCAUSE:   r_mcause   <= w_new;
                    ADDR_MTVAL:    r_mtval    <= w_new;
                    default:       r_mscratch <= r_mscratch;
                endcase
            end
        end
    end

    csr_counter64 u_mcycle (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_inc   (1'b1),
        .i_we    (w_csr_wr & (w_addr == ADDR_MCYCLE)),
        .i_wdata (w_new),
        .o_count (w_mcycle)
    );

    csr_counter64 u_minstret (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_inc   (w_active),
        .i_we    (w_csr_wr & (w_addr == ADDR_MINSTRET)),
        .i_wdata (w_new),
        .o_count (w_minstret)
    );

    // sleep state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // wake ignores mstatus.MIE so a masked interrupt still ends WFI
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_wfi) w_state_next = ST_WFI;
                else       w_state_next = ST_RUN;
            end
            ST_WFI: begin
                if (((w_mip & r_mie) != 64'd0) || w_xcpt) w_state_next = ST_RUN;
                else                                      w_state_next = ST_WFI;
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    logic [63:0] r_rdata, r_evec;
    logic        r_illegal, r_trap, r_eret, r_irq;

    // registered response to the pipeline
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata   <= 64'd0;
            r_evec    <= 64'd0;
            r_illegal <= 1'b0;
            r_trap    <= 1'b0;
            r_eret    <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_rdata   <= w_csr_do ? w_old : 64'd0;
            r_evec    <= w_trap ? r_mtvec : (w_mret ? r_mepc : 64'd0);
            r_illegal <= w_csr_illegal | w_sys_illegal;
            r_trap    <= w_trap;
            r_eret    <= w_mret;
            r_irq     <= r_mie_bit & (|(w_mip & r_mie));
        end
    end

    assign csr_rdata_o   = r_rdata;
    assign csr_evec_o    = r_evec;
    assign csr_illegal_o = r_illegal;
    assign csr_trap_o    = r_trap;
    assign csr_eret_o    = r_eret;
    assign csr_irq_o     = r_irq;
    assign csr_stall_o   = (r_state == ST_WFI);
endmodule

// File: tb/tb_csr_file_m.sv
// Self-checking bench for csr_file_m: directed scenarios plus a randomized run
// compared against a CSR-table reference model.
module tb_csr_file_m;
    localparam logic [63:0] TB_MTVEC_RESET = 64'h0000_0000_8000_1003;
    localparam logic [63:0] TB_HART_ID     = 64'd5;
    localparam logic [2:0] C_NONE = 3'd0, C_WRITE = 3'd1, C_SET = 3'd2,
                           C_CLEAR = 3'd3, C_SYSTEM = 3'd4, C_READ = 3'd5;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [208:0] req_cpu_csr_i;
    logic         irq_timer_i, irq_ext_i;
    logic [63:0]  csr_rdata_o, csr_evec_o;
    logic         csr_illegal_o, csr_trap_o, csr_eret_o, csr_stall_o, csr_irq_o;

    csr_file_m #(.XLEN(64), .MTVEC_RESET(TB_MTVEC_RESET), .HART_ID(TB_HART_ID)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_cpu_csr_i(req_cpu_csr_i),
        .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i),
        .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
        .csr_trap_o(csr_trap_o), .csr_eret_o(csr_eret_o), .csr_evec_o(csr_evec_o),
        .csr_stall_o(csr_stall_o), .csr_irq_o(csr_irq_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    logic tb_irq_t = 1'b0;
    logic tb_irq_e = 1'b0;

    // reference model: CSR table with per-address writable masks
    logic [63:0] m_csr [logic [11:0]];
    logic        m_mtip, m_meip, m_wfi;
    logic [63:0] e_rdata, e_evec;
    logic        e_ill, e_trap, e_eret, e_stall, e_irq;

    task automatic model_reset();
        m_csr.delete();
        m_csr[12'h300] = 64'h1800;
        m_csr[12'h304] = 64'd0;
        m_csr[12'h305] = TB_MTVEC_RESET & ~64'd3;
        m_csr[12'h340] = 64'd0;
        m_csr[12'h341] = 64'd0;
        m_csr[12'h342] = 64'd0;
        m_csr[12'h343] = 64'd0;
        m_csr[12'hB00] = 64'd0;
        m_csr[12'hB02] = 64'd0;
        m_mtip = 1'b0; m_meip = 1'b0; m_wfi = 1'b0;
    endtask

    function automatic logic [63:0] model_mip();
        logic [63:0] v;
        v = 64'd0; v[7] = m_mtip; v[11] = m_meip;
        return v;
    endfunction

    function automatic logic mapped(input logic [11:0] a);
        return m_csr.exists(a) || (a inside {12'h301, 12'h344, 12'hC00, 12'hC02, 12'hF14});
    endfunction

    function automatic logic [63:0] rd(input logic [11:0] a);
        case (a)
            12'h344: return model_mip();
            12'hC00: return m_csr[12'hB00];
            12'hC02: return m_csr[12'hB02];
            12'hF14: return TB_HART_ID;
            default: return m_csr.exists(a) ? m_csr[a] : 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] wmask(input logic [11:0] a);
        case (a)
            12'h300: return 64'h88;
            12'h304: return 64'h880;
            12'h305, 12'h341: return ~64'd3;
            default: return ~64'd0;
        endcase
    endfunction

    task automatic model_step(input logic [11:0] a, input logic [2:0] c, input logic [63:0] wd,
                              input logic x, input logic r, input logic [63:0] cause,
                              input logic [63:0] pc, input logic it, input logic ie);
        logic [63:0] old, nv, st, tcause;
        logic active, do_trap, go_wfi, wr_cyc, wr_ins, wake;
        e_irq = m_csr[12'h300][3] & (|(model_mip() & m_csr[12'h304]));
        wake = ((model_mip() & m_csr[12'h304]) != 64'd0) || x;
        e_rdata = 64'd0; e_evec = 64'd0; e_ill = 1'b0; e_trap = 1'b0; e_eret = 1'b0;
        active = r && !x; do_trap = x; tcause = cause; go_wfi = 1'b0;
        wr_cyc = 1'b0; wr_ins = 1'b0;
        if (active && (c inside {C_WRITE, C_SET, C_CLEAR, C_READ})) begin
            if (!mapped(a) || (c != C_READ && a[11:10] == 2'b11)) begin
                e_ill = 1'b1;
            end else begin
                old = rd(a);
                e_rdata = old;
                nv = (c == C_WRITE) ? wd : ((c == C_SET) ? (old | wd) : (old & ~wd));
                if (c != C_READ && m_csr.exists(a)) begin
                    m_csr[a] = (m_csr[a] & ~wmask(a)) | (nv & wmask(a));
                    wr_cyc = (a == 12'hB00);
                    wr_ins = (a == 12'hB02);
                end
            end
        end else if (active && c == C_SYSTEM) begin
            case (a)
                12'h000: begin do_trap = 1'b1; tcause = 64'd11; end
                12'h001: begin do_trap = 1'b1; tcause = 64'd3; end
                12'h302: begin
                    e_eret = 1'b1; e_evec = m_csr[12'h341];
                    st = m_csr[12'h300]; st[3] = st[7]; st[7] = 1'b1; m_csr[12'h300] = st;
                end
                12'h105: go_wfi = 1'b1;
                default: e_ill = 1'b1;
            endcase
        end
        if (do_trap) begin
            e_trap = 1'b1; e_evec = m_csr[12'h305];
            m_csr[12'h341] = pc & ~64'd3;
            m_csr[12'h342] = tcause;
            st = m_csr[12'h300]; st[7] = st[3]; st[3] = 1'b0; m_csr[12'h300] = st;
        end
        if (!wr_cyc) m_csr[12'hB00] = m_csr[12'hB00] + 64'd1;
        if (active && !wr_ins) m_csr[12'hB02] = m_csr[12'hB02] + 64'd1;
        if (m_wfi) m_wfi = !wake;
        else       m_wfi = go_wfi;
        e_stall = m_wfi;
        m_mtip = it; m_meip = ie;
    endtask

    // drive one request, clock it in, advance the model, sample after the edge
    task automatic step(input logic [11:0] a, input logic [2:0] c, input logic [63:0] wd,
                        input logic x, input logic r, input logic [63:0] cause, input logic [63:0] pc);
        req_cpu_csr_i = {a, c, wd, x, r, cause, pc};
        irq_timer_i = tb_irq_t;
        irq_ext_i = tb_irq_e;
        @(posedge clk_i);
        model_step(a, c, wd, x, r, cause, pc, tb_irq_t, tb_irq_e);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; req_cpu_csr_i = '0; irq_timer_i = 1'b0; irq_ext_i = 1'b0;
        tb_irq_t = 1'b0; tb_irq_e = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({csr_rdata_o, csr_evec_o} !== 128'd0) begin
            errors++; $display("FAIL reset_data got %h %h exp 0", csr_rdata_o, csr_evec_o);
        end
        checks++;
        if ({csr_illegal_o, csr_trap_o, csr_eret_o, csr_stall_o, csr_irq_o} !== 5'd0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000",
                     {csr_illegal_o, csr_trap_o, csr_eret_o, csr_stall_o, csr_irq_o});
        end
    endtask

    task automatic test_mtvec_read();
        step(12'h305, C_READ, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0);
        checks++;
        if (csr_rdata_o !== 64'h8000_1000 || csr_illegal_o !== 1'b0) begin
            errors++; $display("FAIL mtvec_reset got %h ill %b exp 80001000 ill 0", csr_rdata_o, csr_illegal_o);
        end
    endtask

    task automatic test_mscratch();
        logic [63:0] exp_q [$];
        logic [2:0]  cmd_q [$];
        logic [63:0] wd_q  [$];
        cmd_q = '{C_WRITE, C_SET, C_CLEAR, C_READ};
        wd_q  = '{64'hDEADBEEF, 64'hF0, 64'h0F, 64'd0};
        exp_q = '{64'd0, 64'hDEADBEEF, 64'hDEADBEFF, 64'hDEADBEF0};
        for (int i = 0; i < 4; i++) begin
            step(12'h340, cmd_q[i], wd_q[i], 1'b0, 1'b1, 64'd0, 64'd0);
            checks++;
            if (csr_rdata_o !== exp_q[i]) begin
                errors++; $display("FAIL mscratch_%0d got %h exp %h", i, csr_rdata_o, exp_q[i]);
            end
        end
    endtask

    task automatic test_trap();
        step(12'h305, C_WRITE, 64'h100, 1'b0, 1'b1, 64'd0, 64'd0);
        step(12'h300, C_WRITE, 64'h8, 1'b0, 1'b1, 64'd0, 64'd0);
        step(12'h340, C_WRITE, 64'h1234, 1'b1, 1'b1, 64'd2, 64'h8000_0102);
        checks++;
        if (csr_trap_o !== 1'b1 || csr_evec_o !== 64'h100) begin
            errors++; $display("FAIL trap_entry got trap %b evec %h exp 1 100", csr_trap_o, csr_evec_o);
        end
        step(12'h341, C_READ, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0);
        checks++;
        if (csr_rdata_o !== 64'h8000_0100 || csr_trap_o !== 1'b0) begin
            errors++; $display("FAIL trap_mepc got %h trap %b exp 80000100 0", csr_rdata_o, csr_trap_o);
        end
        step(12'h342, C_READ, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0);
        checks++;
        if (csr_rdata_o !== 64'd2) begin
            errors++; $display("FAIL trap_mcause got %h exp 2", csr_rdata_o);
        end
        step(12'h300, C_READ, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0);
        checks++;
        if (csr_rdata_o !== 64'h1880) begin
            errors++; $display("FAIL trap_mstatus got %h exp 1880", csr_rdata_o);
        end
        step(12'h340, C_READ, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0);
        checks++;
        if (csr_rdata_o !== 64'hDEADBEF0) begin
            errors++; $display("FAIL xcpt_drops_write got %h exp deadbef0", csr_rdata_o);
        end
        step(12'h302, C_SYSTEM, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0);
        checks++;
        if (csr_eret_o !== 1'b1 || csr_evec_o !== 64'h8000_0100) begin
            errors++; $display("FAIL mret got eret %b evec %h exp 1 80000100", csr_eret_o, csr_evec_o);
        end
        step(12'h300, C_READ, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0);
        checks++;
        if (csr_rdata_o !== 64'h1888) begin
            errors++; $display("FAIL mret_mstatus got %h exp 1888", csr_rdata_o);
        end
    endtask

    task automatic test_illegal();
        logic [11:0] a_q [$];
        logic [2:0]  c_q [$];
        logic [63:0] r_q [$];
        logic        i_q [$];
        a_q = '{12'hF14, 12'hF14, 12'h7C0, 12'h7FF, 12'hC00};
        c_q = '{C_WRITE, C_READ, C_READ, C_SYSTEM, C_SET};
        r_q = '{64'd0, TB_HART_ID, 64'd0, 64'd0, 64'd0};
        i_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            step(a_q[i], c_q[i], 64'hFF, 1'b0, 1'b1, 64'd0, 64'd0);
            checks++;
            if (csr_illegal_o !== i_q[i] || csr_rdata_o !== r_q[i]) begin
                errors++;
                $display("FAIL illegal_%0d got ill %b rdata %h exp %b %h",
                         i, csr_illegal_o, csr_rdata_o, i_q[i], r_q[i]);
            end
        end
    endtask

    task automatic test_wfi();
        step(12'h304, C_WRITE, 64'h80, 1'b0, 1'b1, 64'd0, 64'd0);
        step(12'h300, C_WRITE, 64'h0, 1'b0, 1'b1, 64'd0, 64'd0);
        step(12'h105, C_SYSTEM, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0);
        step(12'h000, C_NONE, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
        checks++;
        if (csr_stall_o !== 1'b1) begin
            errors++; $display("FAIL wfi_enter got stall %b exp 1", csr_stall_o);
        end
        tb_irq_t = 1'b1;
        step(12'h000, C_NONE, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
        checks++;
        if (csr_stall_o !== 1'b1) begin
            errors++; $display("FAIL wfi_irq_flop got stall %b exp 1", csr_stall_o);
        end
        step(12'h000, C_NONE, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
        checks++;
        if (csr_stall_o !== 1'b0 || csr_irq_o !== 1'b0) begin
            errors++; $display("FAIL wfi_wake got stall %b irq %b exp 0 0", csr_stall_o, csr_irq_o);
        end
        step(12'h344, C_READ, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0);
        checks++;
        if (csr_rdata_o !== 64'h80 || csr_irq_o !== 1'b0) begin
            errors++; $display("FAIL wfi_mip got %h irq %b exp 80 0", csr_rdata_o, csr_irq_o);
        end
        tb_irq_t = 1'b0;
        step(12'h000, C_NONE, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
        step(12'h105, C_SYSTEM, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0);
        do_reset();
        checks++;
        if (csr_stall_o !== 1'b0) begin
            errors++; $display("FAIL wfi_reset got stall %b exp 0", csr_stall_o);
        end
    endtask

    task automatic test_counters();
        logic [63:0] x1, y1, x2, y2;
        step(12'hB00, C_READ, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0); x1 = csr_rdata_o;
        step(12'hB02, C_READ, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0); y1 = csr_rdata_o;
        for (int i = 0; i < 8; i++) step(12'h000, C_NONE, 64'd0, 1'b0, (i == 3), 64'd0, 64'd0);
        step(12'hB00, C_READ, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0); x2 = csr_rdata_o;
        step(12'hB02, C_READ, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0); y2 = csr_rdata_o;
        checks++;
        if (x2 - x1 !== 64'd10 || y2 - y1 !== 64'd3) begin
            errors++; $display("FAIL counter_delta got %0d %0d exp 10 3", x2 - x1, y2 - y1);
        end
        step(12'hB02, C_WRITE, 64'd5, 1'b0, 1'b1, 64'd0, 64'd0);
        step(12'hB02, C_READ, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0);
        checks++;
        if (csr_rdata_o !== 64'd5) begin
            errors++; $display("FAIL minstret_write got %h exp 5", csr_rdata_o);
        end
        step(12'hB00, C_WRITE, ~64'd0, 1'b0, 1'b1, 64'd0, 64'd0);
        step(12'hB00, C_READ, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0);
        checks++;
        if (csr_rdata_o !== ~64'd0) begin
            errors++; $display("FAIL mcycle_max got %h exp ffffffffffffffff", csr_rdata_o);
        end
        step(12'hB00, C_READ, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0);
        checks++;
        if (csr_rdata_o !== 64'd0) begin
            errors++; $display("FAIL mcycle_wrap got %h exp 0", csr_rdata_o);
        end
        step(12'hC02, C_READ, 64'd0, 1'b0, 1'b1, 64'd0, 64'd0);
        checks++;
        if (csr_rdata_o !== 64'd9) begin
            errors++; $display("FAIL instret_alias got %h exp 9", csr_rdata_o);
        end
    endtask

    task automatic test_random();
        logic [11:0] csr_list [15];
        logic [11:0] sys_list [5];
        logic [11:0] a;
        logic [2:0]  c;
        csr_list = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
                     12'hB00, 12'hB02, 12'hC00, 12'hC02, 12'hF14, 12'h7C0, 12'h3A0};
        sys_list = '{12'h000, 12'h001, 12'h302, 12'h105, 12'h7FF};
        for (int n = 0; n < 400; n++) begin
            c = 3'($urandom_range(0, 7));
            a = (c == C_SYSTEM) ? sys_list[$urandom_range(0, 4)] : csr_list[$urandom_range(0, 14)];
            tb_irq_t = ($urandom_range(0, 5) == 0);
            tb_irq_e = ($urandom_range(0, 7) == 0);
            step(a, c, {$urandom, $urandom}, ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
                 64'($urandom_range(0, 15)), {$urandom, $urandom});
            checks++;
            if (csr_rdata_o !== e_rdata || csr_evec_o !== e_evec) begin
                errors++;
                $display("FAIL rand_data step %0d got %h %h exp %h %h", n, csr_rdata_o, csr_evec_o, e_rdata, e_evec);
            end
            checks++;
            if ({csr_illegal_o, csr_trap_o, csr_eret_o, csr_stall_o, csr_irq_o} !==
                {e_ill, e_trap, e_eret, e_stall, e_irq}) begin
                errors++;
                $display("FAIL rand_flags step %0d got %b exp %b", n,
                         {csr_illegal_o, csr_trap_o, csr_eret_o, csr_stall_o, csr_irq_o},
                         {e_ill, e_trap, e_eret, e_stall, e_irq});
            end
        end
    endtask

    initial begin
        test_reset();
        test_mtvec_read();
        test_mscratch();
        test_trap();
        test_illegal();
        test_wfi();
        test_counters();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
